// File: rtl/temporal_mux_pkg.sv
// -----------------------------------------------------------------------------
// temporal_mux_pkg
//
// Purpose:
//   Shared types and width helpers for the temporal-select multiplexer.
//   - tmux_mode_e selects how a channel turns its time-coded select line into
//     a bus index.
//   - The helper functions give the widths of the phase counter, the
//     pulse-width counter and the decoded index for a given gamma-cycle
//     length.
// -----------------------------------------------------------------------------
package temporal_mux_pkg;

  typedef enum logic [1:0] {
    TMUX_RISING  = 2'd0,
    TMUX_FALLING = 2'd1,
    TMUX_PULSE   = 2'd2
  } tmux_mode_e;

  // Phase counter width: holds 0 .. gamma-1.
  function automatic int tmux_phase_w(input int gamma);
    return (gamma > 1) ? $clog2(gamma) : 1;
  endfunction

  // Pulse-width counter width: holds 0 .. gamma.
  function automatic int tmux_cnt_w(input int gamma);
    return $clog2(gamma + 1);
  endfunction

  // Decoded index width. Edge modes yield a phase number and pulse mode
  // yields count-1; both lie in 0 .. gamma-1.
  function automatic int tmux_idx_w(input int gamma);
    return tmux_phase_w(gamma);
  endfunction

endpackage

// File: rtl/tmux_decoder.sv
// -----------------------------------------------------------------------------
// tmux_decoder
//
// Purpose:
//   Per-channel decoder for the temporal-select multiplexer. It observes one
//   sampled select line over a gamma cycle. It reports whether an event was
//   found and which index it encodes.
//   - TMUX_RISING  : phase of the first 0->1 transition (prev forced 0 at phase 0)
//   - TMUX_FALLING : phase of the first 1->0 transition (prev forced 1 at phase 0)
//   - TMUX_PULSE   : number of high phases minus one (saturating count)
//
//   The outputs already include the current phase's sample. The value seen
//   during the final phase therefore covers the whole gamma cycle, including
//   an event at the last phase.
//
// Ports:
//   aclk     in   clock
//   grst     in   asynchronous active-low reset
//   i_sample in   select line value for the current phase
//   i_phase  in   current gamma phase (shared counter)
//   o_found  out  an event has been decoded so far in this gamma cycle
//   o_idx    out  decoded index (meaningful only when o_found is high)
// -----------------------------------------------------------------------------
module tmux_decoder
  import temporal_mux_pkg::*;
#(
  parameter int         GAMMA_CYCLE_WIDTH = 16,
  parameter tmux_mode_e MODE              = TMUX_RISING,
  localparam int        PH_W              = tmux_phase_w(GAMMA_CYCLE_WIDTH),
  localparam int        IDX_W             = tmux_idx_w(GAMMA_CYCLE_WIDTH)
) (
  input  logic             aclk,
  input  logic             grst,
  input  logic             i_sample,
  input  logic [PH_W-1:0]  i_phase,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // Phase 0 starts a fresh gamma cycle. Stored state from the previous cycle
  // is ignored combinationally, so no separate clear cycle is needed.
  logic w_phase0;
  assign w_phase0 = (i_phase == '0);

  if (MODE == TMUX_PULSE) begin : g_pulse

    localparam int             CNT_W   = tmux_cnt_w(GAMMA_CYCLE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GAMMA_CYCLE_WIDTH);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_base;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
      w_cnt_base = w_phase0 ? '0 : r_cnt;
      w_cnt_next = w_cnt_base;
      if (i_sample && (w_cnt_base < CNT_MAX)) begin
        w_cnt_next = w_cnt_base + CNT_W'(1);
      end
    end

    always_ff @(posedge aclk or negedge grst) begin
      if (!grst) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_next;
      end
    end

    // A count of zero is a miss. The index wraps in that case, but it is
    // qualified by o_found.
    assign o_found = (w_cnt_next != '0);
    assign o_idx   = IDX_W'(w_cnt_next - CNT_W'(1));

  end else begin : g_edge

    // Value "prev" takes at phase 0. With 0 a line already high counts as a
    // rising edge at phase 0. With 1 a line already low counts as a falling
    // edge at phase 0.
    localparam logic PREV_INIT = (MODE == TMUX_FALLING);

    logic             r_prev;
    logic             r_found;
    logic [IDX_W-1:0] r_idx;

    logic             w_prev;
    logic             w_found_base;
    logic [IDX_W-1:0] w_idx_base;
    logic             w_edge;
    logic             w_found_next;
    logic [IDX_W-1:0] w_idx_next;

    always_comb begin
      w_prev       = w_phase0 ? PREV_INIT : r_prev;
      w_found_base = w_phase0 ? 1'b0 : r_found;
      w_idx_base   = w_phase0 ? '0 : r_idx;
      if (MODE == TMUX_FALLING) begin
        w_edge = w_prev & ~i_sample;
      end else begin
        w_edge = ~w_prev & i_sample;
      end
      w_found_next = w_found_base | w_edge;
      w_idx_next   = w_idx_base;
      // Only the first edge of the gamma cycle is latched.
      if (!w_found_base && w_edge) begin
        w_idx_next = IDX_W'(i_phase);
      end
    end

    always_ff @(posedge aclk or negedge grst) begin
      if (!grst) begin
        r_prev  <= 1'b0;
        r_found <= 1'b0;
        r_idx   <= '0;
      end else begin
        r_prev  <= i_sample;
        r_found <= w_found_next;
        r_idx   <= w_idx_next;
      end
    end

    assign o_found = w_found_next;
    assign o_idx   = w_idx_next;

  end

endmodule

// File: rtl/temporal_sel_mux.sv
// -----------------------------------------------------------------------------
// temporal_sel_mux
//
// Purpose:
//   Multi-channel temporal-select multiplexer for the race-logic datapath.
//   A shared phase counter divides time into gamma cycles of
//   GAMMA_CYCLE_WIDTH aclk cycles. Each channel decodes its time-coded select
//   line into an index (rising edge, falling edge or pulse width, per MODE).
//   At the final phase the channel picks inputs[idx]. All channels are
//   registered together with a one-cycle y_valid strobe at the start of the
//   next gamma cycle.
//
// Configuration macro:
//   TEMPORAL_SEL_MUX_HOLD_EN
//     - defined   : a channel that misses keeps its previous y value.
//     - undefined : a channel that misses outputs 0 (race-logic null value).
//     In both cases y_hit is 0 on a miss.
//
// Ports:
//   aclk         in   clock (single domain)
//   grst         in   asynchronous active-low reset
//   inputs       in   [NUM_INPUTS][BUS_WIDTH] candidate buses, shared by all
//                     channels; sampled only at the final phase
//   select_line  in   [NUM_CH] temporal select line per channel
//   y            out  [NUM_CH][BUS_WIDTH] selected bus per channel
//   y_hit        out  [NUM_CH] channel decoded an in-range index last cycle
//   y_valid      out  one-cycle strobe when y / y_hit update
//   gamma_phase  out  current phase of the gamma cycle
// -----------------------------------------------------------------------------
module temporal_sel_mux
  import temporal_mux_pkg::*;
#(
  parameter int         GAMMA_CYCLE_WIDTH = 16,
  parameter int         NUM_INPUTS        = 16,
  parameter int         BUS_WIDTH         = 8,
  parameter int         NUM_CH            = 4,
  parameter tmux_mode_e MODE              = TMUX_RISING,
  localparam int        PH_W              = tmux_phase_w(GAMMA_CYCLE_WIDTH)
) (
  input  logic                                 aclk,
  input  logic                                 grst,
  input  logic [NUM_INPUTS-1:0][BUS_WIDTH-1:0] inputs,
  input  logic [NUM_CH-1:0]                    select_line,
  output logic [NUM_CH-1:0][BUS_WIDTH-1:0]     y,
  output logic [NUM_CH-1:0]                    y_hit,
  output logic                                 y_valid,
  output logic [PH_W-1:0]                      gamma_phase
);

  localparam int              IDX_W      = tmux_idx_w(GAMMA_CYCLE_WIDTH);
  localparam logic [PH_W-1:0] PHASE_LAST = PH_W'(GAMMA_CYCLE_WIDTH - 1);

  logic [PH_W-1:0]                  r_phase;
  logic                             w_last;

  logic [NUM_CH-1:0]                w_found;
  logic [NUM_CH-1:0][IDX_W-1:0]     w_idx;
  logic [NUM_CH-1:0]                w_hit;
  logic [NUM_CH-1:0][BUS_WIDTH-1:0] w_sel;

  logic [NUM_CH-1:0][BUS_WIDTH-1:0] r_y;
  logic [NUM_CH-1:0]                r_hit;
  logic                             r_valid;

  // ---- Stage 0: shared phase counter ---------------------------------------
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      r_phase <= '0;
    end else if (r_phase == PHASE_LAST) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

  assign w_last = (r_phase == PHASE_LAST);

  // ---- Stage 1: per-channel decode -----------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tmux_decoder #(
      .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
      .MODE              (MODE)
    ) u_dec (
      .aclk     (aclk),
      .grst     (grst),
      .i_sample (select_line[c]),
      .i_phase  (r_phase),
      .o_found  (w_found[c]),
      .o_idx    (w_idx[c])
    );
  end

  // Range check and bus selection. The select is a compare-and-pick loop
  // rather than a direct array index. The decoded index may be wider than
  // (or exceed) the bus table when NUM_INPUTS < GAMMA_CYCLE_WIDTH.
  always_comb begin
    w_hit = '0;
    w_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_hit[c] = w_found[c] && (int'(w_idx[c]) < NUM_INPUTS);
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (int'(w_idx[c]) == i) begin
          w_sel[c] = inputs[i];
        end
      end
    end
  end

  // ---- Stage 2: output registers, loaded on the edge ending the last phase -
  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      r_y     <= '0;
      r_hit   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_last) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_hit[c] <= w_hit[c];
          if (w_hit[c]) begin
            r_y[c] <= w_sel[c];
          end else begin
`ifdef TEMPORAL_SEL_MUX_HOLD_EN
            r_y[c] <= r_y[c];
`else
            r_y[c] <= '0;
`endif
          end
        end
      end
    end
  end

  assign y           = r_y;
  assign y_hit       = r_hit;
  assign y_valid     = r_valid;
  assign gamma_phase = r_phase;

endmodule
